// File: rtl/lifo_stack_if.sv
// rtl/lifo_stack_if.sv - request/status bundle between a requester and lifo_stack
interface lifo_stack_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [WIDTH-1:0]    d;
  logic                push;
  logic                pop;
  logic                clear;
  logic [WIDTH-1:0]    q;
  logic                q_valid;
  logic [ADDR_WIDTH:0] count;
  logic                empty;
  logic                full;
  logic                overflow;
  logic                underflow;
  logic [ADDR_WIDTH:0] high_water;

  modport master (
    output d, push, pop, clear,
    input  q, q_valid, count, empty, full, overflow, underflow, high_water
  );

  modport slave (
    input  d, push, pop, clear,
    output q, q_valid, count, empty, full, overflow, underflow, high_water
  );
endinterface

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - LIFO with occupancy, replace-top/bypass, sticky error flags and high-water mark
module lifo_stack #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  lifo_stack_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [WIDTH-1:0]      mem [0:(1<<ADDR_WIDTH)-1];

  logic [WIDTH-1:0]      q_r, q_next;
  logic                  q_valid_r, q_valid_next;
  logic [ADDR_WIDTH:0]   count_r, count_next;
  logic                  overflow_r, overflow_next;
  logic                  underflow_r, underflow_next;
  logic [ADDR_WIDTH:0]   high_water_r, high_water_next;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] top_addr;
  logic                  is_empty, is_full;

  assign is_empty = (count_r == '0);
  assign is_full  = (count_r == DEPTH);
  assign top_addr = count_r[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

  always_comb begin
    q_next         = q_r;
    q_valid_next   = 1'b0;
    count_next     = count_r;
    overflow_next  = overflow_r;
    underflow_next = underflow_r;
    wr_en          = 1'b0;
    wr_addr        = count_r[ADDR_WIDTH-1:0];
    if (bus.clear) begin
      q_next         = '0;
      count_next     = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      unique case ({bus.push, bus.pop})
        2'b10: begin
          if (is_full) begin
            overflow_next = 1'b1;
          end else begin
            wr_en      = 1'b1;
            count_next = count_r + (ADDR_WIDTH+1)'(1);
          end
        end
        2'b01: begin
          if (is_empty) begin
            underflow_next = 1'b1;
          end else begin
            q_next       = mem[top_addr];
            q_valid_next = 1'b1;
            count_next   = count_r - (ADDR_WIDTH+1)'(1);
          end
        end
        2'b11: begin
          q_valid_next = 1'b1;
          // Empty stack: the pushed word passes straight through to q.
          if (is_empty) begin
            q_next = bus.d;
          end else begin
            q_next  = mem[top_addr];
            wr_en   = 1'b1;
            wr_addr = top_addr;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    high_water_next = high_water_r;
    if (bus.clear)
      high_water_next = '0;
    else if (count_next > high_water_r)
      high_water_next = count_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r          <= '0;
      q_valid_r    <= 1'b0;
      count_r      <= '0;
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
      high_water_r <= '0;
    end else begin
      q_r          <= q_next;
      q_valid_r    <= q_valid_next;
      count_r      <= count_next;
      overflow_r   <= overflow_next;
      underflow_r  <= underflow_next;
      high_water_r <= high_water_next;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= bus.d;
  end

  assign bus.q          = q_r;
  assign bus.q_valid    = q_valid_r;
  assign bus.count      = count_r;
  assign bus.empty      = is_empty;
  assign bus.full       = is_full;
  assign bus.overflow   = overflow_r;
  assign bus.underflow  = underflow_r;
  assign bus.high_water = high_water_r;
endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - directed vector bench for lifo_stack (depth 4, 8-bit words)
module tb_lifo_stack;
  localparam int W  = 8;
  localparam int AW = 2;

  logic clk;
  logic reset;

  lifo_stack_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  lifo_stack #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // op = {push, pop, clear}; flags = {empty, full, overflow, underflow}
  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         qv;
    logic [AW:0]  cnt;
    logic [3:0]   flags;
    logic [AW:0]  hw;
  } vec_t;

  vec_t vq[$];
  int   n_cmp;
  int   n_bad;

  function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] d, input logic [W-1:0] q,
                              input logic qv, input logic [AW:0] cnt, input logic [3:0] flags,
                              input logic [AW:0] hw);
    vec_t v;
    v.op = op; v.d = d; v.q = q; v.qv = qv; v.cnt = cnt; v.flags = flags; v.hw = hw;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [W-1:0] q, input logic qv, input logic [AW:0] cnt,
                           input logic [3:0] flags, input logic [AW:0] hw);
    check("q", idx, 32'(bus.q), 32'(q));
    check("q_valid", idx, 32'(bus.q_valid), 32'(qv));
    check("count", idx, 32'(bus.count), 32'(cnt));
    check("flags", idx, 32'({bus.empty, bus.full, bus.overflow, bus.underflow}), 32'(flags));
    check("high_water", idx, 32'(bus.high_water), 32'(hw));
  endtask

  task automatic step(input logic [2:0] op, input logic [W-1:0] d);
    @(negedge clk);
    {bus.push, bus.pop, bus.clear} = op;
    bus.d = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0; bus.d = '0;
    #12;
    check_all(-1, 8'h00, 1'b0, 3'd0, 4'b1000, 3'd0);
    reset = 1'b0;

    // three pushes then three pops
    vq.push_back(mk(3'b100, 8'h11, 8'h00, 1'b0, 3'd1, 4'b0000, 3'd1));
    vq.push_back(mk(3'b100, 8'h22, 8'h00, 1'b0, 3'd2, 4'b0000, 3'd2));
    vq.push_back(mk(3'b100, 8'h33, 8'h00, 1'b0, 3'd3, 4'b0000, 3'd3));
    vq.push_back(mk(3'b010, 8'h00, 8'h33, 1'b1, 3'd2, 4'b0000, 3'd3));
    vq.push_back(mk(3'b010, 8'h00, 8'h22, 1'b1, 3'd1, 4'b0000, 3'd3));
    vq.push_back(mk(3'b010, 8'h00, 8'h11, 1'b1, 3'd0, 4'b1000, 3'd3));
    // replace-top then pop the replacement
    vq.push_back(mk(3'b100, 8'h05, 8'h11, 1'b0, 3'd1, 4'b0000, 3'd3));
    vq.push_back(mk(3'b110, 8'h06, 8'h05, 1'b1, 3'd1, 4'b0000, 3'd3));
    vq.push_back(mk(3'b010, 8'h00, 8'h06, 1'b1, 3'd0, 4'b1000, 3'd3));
    // empty bypass
    vq.push_back(mk(3'b110, 8'h77, 8'h77, 1'b1, 3'd0, 4'b1000, 3'd3));
    // fill, replace-top while full, overflow, drain, underflow
    vq.push_back(mk(3'b100, 8'hA1, 8'h77, 1'b0, 3'd1, 4'b0000, 3'd3));
    vq.push_back(mk(3'b100, 8'hA2, 8'h77, 1'b0, 3'd2, 4'b0000, 3'd3));
    vq.push_back(mk(3'b100, 8'hA3, 8'h77, 1'b0, 3'd3, 4'b0000, 3'd3));
    vq.push_back(mk(3'b100, 8'hA4, 8'h77, 1'b0, 3'd4, 4'b0100, 3'd4));
    vq.push_back(mk(3'b110, 8'hB5, 8'hA4, 1'b1, 3'd4, 4'b0100, 3'd4));
    vq.push_back(mk(3'b100, 8'hAA, 8'hA4, 1'b0, 3'd4, 4'b0110, 3'd4));
    vq.push_back(mk(3'b010, 8'h00, 8'hB5, 1'b1, 3'd3, 4'b0010, 3'd4));
    vq.push_back(mk(3'b010, 8'h00, 8'hA3, 1'b1, 3'd2, 4'b0010, 3'd4));
    vq.push_back(mk(3'b010, 8'h00, 8'hA2, 1'b1, 3'd1, 4'b0010, 3'd4));
    vq.push_back(mk(3'b010, 8'h00, 8'hA1, 1'b1, 3'd0, 4'b1010, 3'd4));
    vq.push_back(mk(3'b010, 8'h00, 8'hA1, 1'b0, 3'd0, 4'b1011, 3'd4));
    vq.push_back(mk(3'b000, 8'h00, 8'hA1, 1'b0, 3'd0, 4'b1011, 3'd4));
    // clear wipes flags and high-water, and overrides push/pop
    vq.push_back(mk(3'b001, 8'h00, 8'h00, 1'b0, 3'd0, 4'b1000, 3'd0));
    vq.push_back(mk(3'b100, 8'hC1, 8'h00, 1'b0, 3'd1, 4'b0000, 3'd1));
    vq.push_back(mk(3'b100, 8'hC2, 8'h00, 1'b0, 3'd2, 4'b0000, 3'd2));
    vq.push_back(mk(3'b100, 8'hC3, 8'h00, 1'b0, 3'd3, 4'b0000, 3'd3));
    vq.push_back(mk(3'b111, 8'hDD, 8'h00, 1'b0, 3'd0, 4'b1000, 3'd0));
    vq.push_back(mk(3'b010, 8'h00, 8'h00, 1'b0, 3'd0, 4'b1001, 3'd0));

    foreach (vq[i]) begin
      step(vq[i].op, vq[i].d);
      check_all(i, vq[i].q, vq[i].qv, vq[i].cnt, vq[i].flags, vq[i].hw);
    end

    // asynchronous reset between edges
    step(3'b100, 8'hE1);
    step(3'b100, 8'hE2);
    step(3'b010, 8'h00);
    check_all(100, 8'hE2, 1'b1, 3'd1, 4'b0001, 3'd2);
    #2;
    reset = 1'b1;
    #1;
    check_all(101, 8'h00, 1'b0, 3'd0, 4'b1000, 3'd0);
    reset = 1'b0;
    step(3'b100, 8'h09);
    step(3'b010, 8'h00);
    check_all(102, 8'h09, 1'b1, 3'd0, 4'b1000, 3'd1);
    step(3'b000, 8'h00);
    check_all(103, 8'h09, 1'b0, 3'd0, 4'b1000, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lifo_stack.md
# lifo_stack

Parametrised LIFO buffer, successor to the basic stack used by the labelling and region-tracking stages. Adds correct full/empty detection, an occupancy count, same-cycle push+pop (replace-top and empty bypass), a registered pop-valid strobe, sticky overflow/underflow flags, a synchronous flush, and a high-water mark for sizing studies. Sits between the label-resolution FSM and its work-list storage; one push or pop per cycle, no stalls.

## Interface
- WIDTH, 32, data word width in bits
- ADDR_WIDTH, 8, log2 of depth; DEPTH = 2^ADDR_WIDTH entries
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- d  input  WIDTH  data to push
- push  input  1  push request
- pop  input  1  pop request
- clear  input  1  synchronous flush
- q  output  WIDTH  popped data, registered
- q_valid  output  1  one-cycle strobe: q updated by a pop this edge
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky: push refused while full
- underflow  output  1  sticky: pop refused while empty
- high_water  output  ADDR_WIDTH+1  maximum count since reset/clear

## Operation
- Storage: DEPTH×WIDTH array, not reset; entry count-1 is top.
- Priority per edge: reset (async) > clear > push/pop decode.
- clear: count←0, q←0, q_valid←0, overflow←0, underflow←0, high_water←0; push/pop ignored that cycle.
- push only, not full: mem[count]←d, count+1, q_valid←0.
- push only, full: no write, count unchanged, overflow←1.
- pop only, not empty: q←mem[count-1], q_valid←1, count-1.
- pop only, empty: q unchanged, q_valid←0, underflow←1.
- push+pop, not empty (including full): q←old top, q_valid←1, mem[count-1]←d, count unchanged; no overflow.
- push+pop, empty: bypass; q←d, q_valid←1, count stays 0; no underflow.
- Idle: q holds last value, q_valid←0, count unchanged.
- high_water←max(high_water, next count) every non-clear edge.
- overflow/underflow clear only via reset or clear.
- empty, full combinational from count; count registered.

## Timing
- Reset values: q=0, q_valid=0, count=0, empty=1, full=0, overflow=0, underflow=0, high_water=0.
- Reset asserted mid-operation: all state above returns to reset values immediately, independent of clk; memory contents undefined afterward.
- Pop latency: 1 cycle; q/q_valid valid after the edge sampling pop; q_valid high exactly one cycle per accepted pop.
- count/empty/full/high_water reflect a push or pop after the same edge.
- Back-to-back push or pop every cycle supported; push then pop next cycle returns the just-pushed word.
- No ready/backpressure; requester must check full/empty, otherwise the request is dropped and flagged.

## Test plan
- Reset then push 0x11,0x22,0x33 over 3 cycles, pop 3 cycles -> q=0x33,0x22,0x11 with q_valid each cycle, count 3→0, empty=1, high_water=3.
- Fill ADDR_WIDTH=2 instance with 4 pushes, then push 0xAA -> full=1, count=4, overflow=1; pop 4 -> no 0xAA returned; 5th pop -> q_valid=0, underflow=1.
- Push 0x5, then push 0x6 with pop same cycle -> q=0x5, q_valid=1, count=1; next pop -> q=0x6.
- Empty, push 0x77 with pop -> q=0x77, q_valid=1, count=0, underflow=0; on full stack push+pop -> no overflow, count=DEPTH.
- Push 3 words, assert clear with pop -> count=0, q=0, q_valid=0, flags and high_water=0; subsequent pop -> underflow=1.
- Push 2 words, assert reset between edges -> outputs reach reset values before next clk edge; push 0x9 after release then pop -> q=0x9.
